serial_paralelo_alineado: RTL
=============================

# serial_paralelo_alineado

Serial-to-parallel receiver for the 10-bit serial link driven by `paraleloSerial`. It shifts in one bit per enabled `clk` cycle and finds word boundaries by detecting the K28.5 comma. It declares lock after a programmable number of aligned commas, then presents each received 10-bit word with a one-cycle valid strobe. It sits at the receive end of the link, feeding the 10b decoding logic, and runs on the fast bit clock only, with no `clk10` input.

## Interface
- `COMAS_LOCK`, default 4: number of consecutive aligned commas required to enter LOCKED; legal range 1–15.
- `clk` input 1: bit clock; all state changes on the rising edge.
- `rst` input 1: asynchronous, active-low reset.
- `enb` input 1: bit enable. When low, all state holds and no bit is sampled.
- `entrada` input 1: serial data, MSB first (bit 9 of each word is sent first).
- `salidas` output 10: last captured word, MSB = first received bit.
- `valido` output 1: one-cycle pulse; `salidas` updated with a new word (LOCKED only).
- `esComa` output 1: `salidas` holds a comma; qualified by `valido`.
- `sincronizado` output 1: high while in LOCKED.
- `errorAlineacion` output 1: one-cycle pulse when a comma is seen off-boundary in CHECK or LOCKED.

## Operation
- The receive window is `w = {sr[8:0], entrada}`, where `sr` is the 10-bit shift register. On every enabled cycle, `sr <= w`.
- A comma is `w == 10'b0011111010` or `w == 10'b1100000101`.
- Bit counter `cnt`, 4 bits:
  - counts 0..9 on every enabled cycle;
  - 9 wraps to 0;
  - the word boundary is `cnt == 9`, meaning the 10th bit of the word is being sampled.
- States: SEARCH (reset state), CHECK, LOCKED. Comma counter `nComas` is 4 bits.
- SEARCH:
  - `cnt` is ignored.
  - On a comma: `cnt <= 0`, `nComas <= 1`, go to CHECK.
  - If `COMAS_LOCK == 1`, go directly to LOCKED instead.
- CHECK, at a boundary:
  - comma: `nComas <= nComas+1`; when the new value equals `COMAS_LOCK`, go to LOCKED.
  - non-comma: `nComas <= 0`, go to SEARCH. No error pulse.
- LOCKED, at a boundary:
  - `salidas <= w`, `valido <= 1`, `esComa <= (w is comma)`.
  - Non-comma data never drops lock.
- CHECK or LOCKED, comma with `cnt != 9` (misaligned):
  - `errorAlineacion <= 1`, `sincronizado <= 0`;
  - realign immediately: `cnt <= 0`, `nComas <= 1`, state CHECK (LOCKED if `COMAS_LOCK == 1`).
- Priority within one cycle: misaligned comma > boundary handling. A comma exactly at the boundary is aligned.
- `enb` low: `sr`, `cnt`, state, `nComas` and `salidas` hold. `valido` and `errorAlineacion` go to 0 on that cycle, so pulses are never stretched.
- Reset (`rst` = 0, any time, including mid-word) immediately forces:
  - `sr = 0`, `cnt = 0`, `nComas = 0`, state SEARCH;
  - `salidas = 10'b0`, `valido = 0`, `esComa = 0`, `sincronizado = 0`, `errorAlineacion = 0`.
- Reset release takes effect at the first rising edge with `rst` = 1.

## Timing
- All outputs are registered. There is no combinational path from `entrada` to any output.
- Latency: when the 10th bit of a word is sampled at edge N, `salidas`, `valido` and `esComa` are valid in the cycle following edge N. `valido` falls at edge N+1 unless N+1 is also a boundary, which cannot happen because boundaries are 10 enabled cycles apart.
- `sincronizado` rises in the cycle after the edge that samples the last bit of the `COMAS_LOCK`-th comma. The `valido` pulse for that comma is not issued; the first `valido` is for the next word.
- `errorAlineacion` and `sincronizado` falling occur in the cycle after the edge that samples the misaligned comma's last bit.
- With `enb` held high, the minimum spacing between `valido` pulses is 10 cycles.

## Test plan
- Reset, then stream 4 × `0011111010` MSB first with `enb` = 1 → `sincronizado` = 1 at cycle 41 (bit 40 sampled at edge 40); no `valido` or `errorAlineacion` before that.
- Once locked, send `1101101100`, `1111100000`, `0000011111` → three `valido` pulses 10 cycles apart, `salidas` = each word in order, `esComa` = 0. A following `1100000101` gives `valido` with `esComa` = 1.
- Once locked, insert 3 stray bits `101`, then a comma → one `errorAlineacion` pulse, `sincronizado` = 0. Four more commas then give `sincronizado` = 1 with `cnt` phase shifted by 3.
- In CHECK (after 2 commas), send a non-comma word `1010010101` → back to SEARCH, `errorAlineacion` stays 0. Relock needs 4 fresh commas.
- Once locked, drop `enb` for 7 cycles mid-word, then resume → the word completes correctly after 10 enabled bits with one `valido`, and no pulse occurs while `enb` = 0.
- Assert `rst` = 0 asynchronously between edges mid-word while LOCKED → all outputs 0 immediately. After release, a single `valido` never appears before re-lock.

Source files
------------

// File: rtl/serial_paralelo_alineado.sv
// serial_paralelo_alineado
//   Serial-to-parallel receiver for the 10-bit link. Shifts in one bit per
//   enabled clk cycle (MSB first), locates word boundaries with the K28.5
//   comma and, once COMAS_LOCK aligned commas have been seen in a row,
//   presents every received word with a one-cycle valid strobe.
//
// Parameters
//   COMAS_LOCK      consecutive aligned commas needed to lock (1..15)
// Ports
//   clk             bit clock, rising edge
//   rst             asynchronous reset, active low
//   enb             bit enable; low holds all state, pulses drop to 0
//   entrada         serial data in, bit 9 of each word first
//   salidas         last word captured while locked
//   valido          one-cycle strobe: salidas just updated
//   esComa          salidas holds a comma (qualified by valido)
//   sincronizado    high while locked
//   errorAlineacion one-cycle pulse: comma seen off-boundary in CHECK/LOCKED
module serial_paralelo_alineado #(
  parameter int unsigned COMAS_LOCK = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enb,
  input  logic       entrada,
  output logic [9:0] salidas,
  output logic       valido,
  output logic       esComa,
  output logic       sincronizado,
  output logic       errorAlineacion
);

  typedef enum logic [1:0] {StSearch, StCheck, StLocked} state_e;

  localparam logic [9:0] CommaNeg  = 10'b0011111010;
  localparam logic [9:0] CommaPos  = 10'b1100000101;
  localparam logic [3:0] LockCount = 4'(COMAS_LOCK);
  // With a single required comma, any (re)alignment goes straight to lock.
  localparam state_e     AlignSt   = (COMAS_LOCK == 1) ? StLocked : StCheck;

  state_e     state_q, state_d;
  logic [9:0] sr_q, sr_d;
  logic [3:0] cnt_q, cnt_d;
  logic [3:0] n_comas_q, n_comas_d;
  logic [9:0] salidas_q, salidas_d;
  logic       valido_q, valido_d;
  logic       es_coma_q, es_coma_d;
  logic       sinc_q, sinc_d;
  logic       err_q, err_d;

  logic [9:0] w;
  logic       is_comma;
  logic       boundary;
  logic       misaligned;

  assign w          = {sr_q[8:0], entrada};
  assign is_comma   = (w == CommaNeg) || (w == CommaPos);
  assign boundary   = (cnt_q == 4'd9);
  // A comma exactly on the boundary is aligned; SEARCH never flags errors.
  assign misaligned = is_comma && !boundary && (state_q != StSearch);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    cnt_d     = cnt_q;
    n_comas_d = n_comas_q;
    salidas_d = salidas_q;
    valido_d  = 1'b0;
    es_coma_d = es_coma_q;
    sinc_d    = sinc_q;
    err_d     = 1'b0;

    if (enb) begin
      sr_d  = w;
      cnt_d = boundary ? 4'd0 : cnt_q + 4'd1;

      unique case (state_q)
        StSearch: begin
          if (is_comma) begin
            cnt_d     = 4'd0;
            n_comas_d = 4'd1;
            state_d   = AlignSt;
          end
        end
        StCheck, StLocked: begin
          if (misaligned) begin
            err_d     = 1'b1;
            cnt_d     = 4'd0;
            n_comas_d = 4'd1;
            state_d   = AlignSt;
          end else if (boundary) begin
            if (state_q == StCheck) begin
              if (is_comma) begin
                n_comas_d = n_comas_q + 4'd1;
                if ((n_comas_q + 4'd1) == LockCount) state_d = StLocked;
              end else begin
                n_comas_d = 4'd0;
                state_d   = StSearch;
              end
            end else begin
              salidas_d = w;
              valido_d  = 1'b1;
              es_coma_d = is_comma;
            end
          end
        end
        default: state_d = StSearch;
      endcase

      sinc_d = (state_d == StLocked) && !misaligned;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= StSearch;
      sr_q      <= '0;
      cnt_q     <= '0;
      n_comas_q <= '0;
      salidas_q <= '0;
      valido_q  <= 1'b0;
      es_coma_q <= 1'b0;
      sinc_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      sr_q      <= sr_d;
      cnt_q     <= cnt_d;
      n_comas_q <= n_comas_d;
      salidas_q <= salidas_d;
      valido_q  <= valido_d;
      es_coma_q <= es_coma_d;
      sinc_q    <= sinc_d;
      err_q     <= err_d;
    end
  end

  assign salidas         = salidas_q;
  assign valido          = valido_q;
  assign esComa          = es_coma_q;
  assign sincronizado    = sinc_q;
  assign errorAlineacion = err_q;

endmodule
